// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with run-time modulus, variable step,
// parallel load, wrap/saturate mode and registered wrap/err status pulses.
module updown_counter_param #(
    parameter int WIDTH     = 8,
    parameter int STEP_W    = 4,
    parameter int RESET_VAL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic              sat_mode,
    input  logic [WIDTH-1:0]  mod_val,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_val,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_zero,
    output logic              wrap,
    output logic              err
);

    logic [WIDTH-1:0] step_w;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH-1:0] up_wrapped;
    logic [WIDTH-1:0] dn_wrapped;
    logic [WIDTH-1:0] next_count;
    logic             next_wrap;
    logic             next_err;

    assign step_w = WIDTH'(step);
    // One extra bit on the sum so c+s never overflows before comparing to m.
    assign sum_up = {1'b0, count} + {1'b0, step_w};
    // Wrapped results always land in 0..m, so modular WIDTH-bit arithmetic is exact.
    assign up_wrapped = count + step_w - mod_val - WIDTH'(1);
    assign dn_wrapped = count + mod_val + WIDTH'(1) - step_w;

    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        next_err   = 1'b0;
        if (load) begin
            next_count = (load_val > mod_val) ? mod_val : load_val;
        end else if (en) begin
            if (count > mod_val) begin
                // Modulus was lowered under us: pull back into range, ignore step.
                next_count = mod_val;
            end else if (step_w > mod_val) begin
                next_err = 1'b1;
            end else if (step_w == '0) begin
                next_count = count;
            end else if (up_down) begin
                if (sum_up > {1'b0, mod_val}) begin
                    next_wrap  = 1'b1;
                    next_count = sat_mode ? mod_val : up_wrapped;
                end else begin
                    next_count = sum_up[WIDTH-1:0];
                end
            end else begin
                if (step_w > count) begin
                    next_wrap  = 1'b1;
                    next_count = sat_mode ? '0 : dn_wrapped;
                end else begin
                    next_count = count - step_w;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= WIDTH'(RESET_VAL);
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            count <= next_count;
            wrap  <= next_wrap;
            err   <= next_err;
        end
    end

    assign at_max  = (count == mod_val);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param (WIDTH=4): expected results are queued
// as each cycle is driven and compared after the edge that produces them.
module tb_updown_counter_param;

    localparam int WIDTH = 4;
    localparam int W     = 8;

    logic             clk;
    logic             reset;
    logic             en;
    logic             up_down;
    logic [3:0]       step;
    logic             sat_mode;
    logic [WIDTH-1:0] mod_val;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             at_max;
    logic             at_zero;
    logic             wrap;
    logic             err;

    logic [W-1:0] exp_q[$];
    int checks;
    int errors;
    int wrap_seen;

    updown_counter_param #(.WIDTH(4), .STEP_W(4), .RESET_VAL(0)) dut (
        .clk(clk), .reset(reset), .en(en), .up_down(up_down), .step(step),
        .sat_mode(sat_mode), .mod_val(mod_val), .load(load), .load_val(load_val),
        .count(count), .at_max(at_max), .at_zero(at_zero), .wrap(wrap), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compared vector: {count, wrap, err, at_max, at_zero}
    task automatic check_out(input string tag);
        logic [W-1:0] exp_v;
        logic [W-1:0] obs_v;
        obs_v = {count, wrap, err, at_max, at_zero};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed=%b expected=<empty queue>", tag, obs_v);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs_v === exp_v) else begin
                errors++;
                $error("FAIL %s: observed={cnt=%0d wrap=%b err=%b max=%b zero=%b} expected={cnt=%0d wrap=%b err=%b max=%b zero=%b}",
                       tag, obs_v[7:4], obs_v[3], obs_v[2], obs_v[1], obs_v[0],
                       exp_v[7:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    task automatic cyc(input string tag, input logic rst, input logic ld, input logic e,
                       input logic ud, input logic sm, input logic [3:0] st,
                       input logic [3:0] mv, input logic [3:0] lv,
                       input logic [3:0] ec, input logic ew, input logic ee);
        reset    = rst;
        load     = ld;
        en       = e;
        up_down  = ud;
        sat_mode = sm;
        step     = st;
        mod_val  = mv;
        load_val = lv;
        exp_q.push_back({ec, ew, ee, (ec == mv), (ec == 4'd0)});
        @(posedge clk);
        #1;
        if (wrap) wrap_seen++;
        check_out(tag);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        wrap_seen = 0;
        reset = 1'b1; en = 1'b0; up_down = 1'b1; step = '0; sat_mode = 1'b0;
        mod_val = 4'd9; load = 1'b0; load_val = '0;
        @(posedge clk);
        #1;

        // Reset state and reset mid-count
        cyc("reset0",     1, 0, 0, 1, 0, 0,  9,  0,  0, 0, 0);
        cyc("load9",      0, 1, 0, 1, 0, 0, 15,  9,  9, 0, 0);
        cyc("rst_mid",    1, 1, 1, 1, 0, 1, 15,  9,  0, 0, 0);
        cyc("rst_hold2",  1, 1, 1, 1, 0, 1, 15,  9,  0, 0, 0);
        cyc("rst_hold3",  1, 1, 1, 1, 0, 1, 15,  9,  0, 0, 0);

        // Wrap mode up and down
        cyc("ld8",        0, 1, 0, 1, 0, 0,  9,  8,  8, 0, 0);
        cyc("wrap_up",    0, 0, 1, 1, 0, 3,  9,  0,  1, 1, 0);
        cyc("after_wrap", 0, 0, 1, 1, 0, 3,  9,  0,  4, 0, 0);
        cyc("ld1",        0, 1, 0, 0, 0, 0,  9,  1,  1, 0, 0);
        cyc("wrap_dn",    0, 0, 1, 0, 0, 3,  9,  0,  8, 1, 0);

        // Saturate mode, including holding at the bounds
        cyc("ld11",       0, 1, 0, 1, 1, 0, 12, 11, 11, 0, 0);
        cyc("sat_up",     0, 0, 1, 1, 1, 2, 12,  0, 12, 1, 0);
        cyc("sat_up_hold",0, 0, 1, 1, 1, 2, 12,  0, 12, 1, 0);
        cyc("sat_dn1",    0, 0, 1, 0, 1, 5, 12,  0,  7, 0, 0);
        cyc("sat_dn2",    0, 0, 1, 0, 1, 5, 12,  0,  2, 0, 0);
        cyc("sat_dn3",    0, 0, 1, 0, 1, 5, 12,  0,  0, 1, 0);
        cyc("sat_dn_hold",0, 0, 1, 0, 1, 5, 12,  0,  0, 1, 0);

        // Load clamp and priority, enable low, reset over load
        cyc("ld_clamp",   0, 1, 1, 1, 0, 1, 10, 14, 10, 0, 0);
        cyc("en_low",     0, 0, 0, 1, 0, 3, 10,  0, 10, 0, 0);
        cyc("rst_ld",     1, 1, 1, 1, 0, 1, 10, 14,  0, 0, 0);

        // Illegal step, step zero, out-of-range recovery, mod_val=0
        cyc("illegal",    0, 0, 1, 1, 0, 7,  5,  0,  0, 0, 1);
        cyc("step0",      0, 0, 1, 1, 0, 0,  5,  0,  0, 0, 0);
        cyc("ld3",        0, 1, 0, 1, 1, 0,  5,  3,  3, 0, 0);
        cyc("illegal_sat",0, 0, 1, 0, 1, 6,  5,  0,  3, 0, 1);
        cyc("ld9",        0, 1, 0, 1, 0, 0, 15,  9,  9, 0, 0);
        cyc("recover",    0, 0, 1, 1, 0, 1,  5,  0,  5, 0, 0);
        cyc("ld_mod0",    0, 1, 0, 1, 0, 0,  0,  7,  0, 0, 0);
        cyc("mod0_step",  0, 0, 1, 1, 0, 1,  0,  0,  0, 0, 1);
        cyc("mod0_clear", 0, 0, 0, 1, 0, 1,  0,  0,  0, 0, 0);

        // Full-range wrap with enable-low gaps
        wrap_seen = 0;
        for (int i = 1; i <= 32; i++) begin
            logic [3:0] ec;
            ec = 4'(i % 16);
            cyc("full_up", 0, 0, 1, 1, 0, 1, 15, 0, ec, (ec == 4'd0), 0);
            if (i == 8 || i == 20) begin
                cyc("full_gap", 0, 0, 0, 1, 0, 1, 15, 0, ec, 0, 0);
            end
        end
        checks++;
        assert (wrap_seen === 2) else begin
            errors++;
            $error("FAIL wrap_pulses: observed=%0d expected=2", wrap_seen);
        end

        checks++;
        assert (exp_q.size() === 0) else begin
            errors++;
            $error("FAIL queue_drain: observed=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
Parametrised synchronous up/down counter that generalises the team's fixed 3-bit async-reset up/down counter. It adds:
- configurable width
- run-time programmable modulus (terminal value)
- variable step size
- parallel load
- selectable wrap/saturate mode
- registered terminal/overflow/error status

It is used as a general-purpose event, address and credit counter inside single-clock datapaths.

Parameters:
WIDTH, 8, counter width in bits; count range 0..2^WIDTH-1.
STEP_W, 4, width of step input; STEP_W <= WIDTH.
RESET_VAL, 0, value loaded into count on reset; must be <= 2^WIDTH-1.

Ports:
clk  input  1  rising-edge clock; all state updates on posedge clk.
reset  input  1  synchronous active-high reset.
en  input  1  count enable; no change when low (except load/reset).
up_down  input  1  direction: 1 = count up, 0 = count down.
step  input  STEP_W  increment/decrement magnitude; 0 = hold (no flags).
sat_mode  input  1  1 = saturate at bounds, 0 = wrap modulo (mod_val+1).
mod_val  input  WIDTH  terminal value; count range is 0..mod_val.
load  input  1  synchronous parallel load, independent of en.
load_val  input  WIDTH  value for load.
count  output  WIDTH  registered counter value.
at_max  output  1  count == mod_val (decoded from registered count).
at_zero  output  1  count == 0 (decoded from registered count).
wrap  output  1  registered one-cycle pulse: bound crossed (wrapped or clipped).
err  output  1  registered one-cycle pulse: illegal step (step > mod_val) on an enabled cycle.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: on posedge clk with reset=1, count <= RESET_VAL and wrap <= 0, err <= 0. Reset overrides everything.
- Priority per edge: reset > load > en. With en=0 and load=0, count holds, and wrap=0, err=0 next cycle.
- Load: count <= min(load_val, mod_val). wrap=0, err=0. Load ignores en, up_down and step.
- Out-of-range recovery: on an enabled, non-load cycle where count > mod_val (mod_val lowered at run time), count <= mod_val. No wrap, no err, step ignored.
- Illegal step: on an enabled cycle with step > mod_val, count holds and err pulses for 1 cycle. This applies in both modes.
- Up, legal step (s = step, c = count, m = mod_val; internal sum is WIDTH+1 bits, so no overflow):
  - c+s <= m: count <= c+s, wrap=0.
  - c+s > m, wrap mode: count <= c+s-(m+1), wrap=1.
  - c+s > m, saturate mode: count <= m, wrap=1.
- Down, legal step:
  - s <= c: count <= c-s, wrap=0.
  - s > c, wrap mode: count <= c+(m+1)-s, wrap=1.
  - s > c, saturate mode: count <= 0, wrap=1.
- Saturate-mode hold: if count is already m and direction is up (or count is 0 and direction is down) with s>0, count holds and wrap still pulses.
- step=0 with en=1: count holds, wrap=0, err=0.
- Latency: count, wrap and err all update on the same edge, one cycle after the inputs are sampled. at_max and at_zero are combinational from the registered count and current mod_val, with no added latency.
- mod_val=0: the legal range is {0}. Any step>0 asserts err. Load clamps to 0.
- Inputs are sampled only at posedge. There are no asynchronous paths, and no combinational path exists from inputs to count, wrap or err.
- Synthesisable, with no latches. The expected implementation is 120-250 lines of RTL.

Test Plan:
Bench config: WIDTH=4, STEP_W=4, RESET_VAL=0.
1. Reset mid-count: count=9, assert reset with en=1, load=1 -> next cycle count=0, wrap=0, err=0. Hold reset 3 cycles -> count stays 0.
2. Wrap up: mod_val=9, step=3, count=8, up, sat_mode=0 -> count=1 with wrap=1 for exactly 1 cycle, then count=4 with wrap=0. Wrap down: mod_val=9, count=1, step=3, down -> count=8, wrap=1.
3. Saturate: mod_val=12, count=11, step=2, up, sat_mode=1 -> count=12, wrap=1, at_max=1. Next cycle: count=12, wrap=1. Then down, step=5 ×3 -> 7, 2, then 0 with wrap=1 and at_zero=1.
4. Load priority and clamp: en=1, up, load=1, load_val=14, mod_val=10 -> count=10, wrap=0. load=1 with reset=1 -> count=0.
5. Illegal step and mod change: mod_val=5, step=7, en=1 -> count holds, err=1 for 1 cycle. With count=9, set mod_val=5, step=1, up -> count=5, wrap=0, err=0.
6. Full-range wrap: mod_val=15, step=1, 32 enabled up cycles from 0 -> count sequence 0..15,0..15, wrap pulses exactly twice (at the 15->0 edges). en=0 cycles inserted -> count holds, no pulses.
